vector_lane_serializer: RTL and testbench
=========================================

# vector_lane_serializer

Streams a registered N-lane vector out one lane per cycle over a valid/ready handshake. It is the consumer-side counterpart of the lane-parallel vector datapath: it accepts a whole W×N result vector in one beat and emits lane 0 through lane N-1 to a scalar sink. Placement is directly after the vector adder's output registers, feeding narrow downstream logic or a test harness.

## Interface
- W, 8, lane width in bits
- N, 4, lanes per vector (N ≥ 1)
- IW, (N > 1 ? $clog2(N) : 1), lane index width (derived, not overridden)

- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_vec holds a vector to capture
- in_ready  output  1  block captures in_vec this cycle if in_valid
- in_vec  input  [W-1:0] x [N-1:0] (unpacked)  vector to serialize; lane i is in_vec[i]
- out_valid  output  1  out_data holds a valid lane
- out_ready  input  1  sink accepts the current lane
- out_data  output  W  current lane value
- out_index  output  IW  lane number of out_data
- out_last  output  1  current lane is lane N-1

## Operation
- State: IDLE, SEND. Internal: buf[N] (W bits each), idx (IW bits).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- IDLE: in_ready=1, out_valid=0. On input transfer: buf<=in_vec, idx<=0, next SEND.
- SEND: out_valid=1, out_data=buf[idx], out_index=idx, out_last=(idx==N-1).
  - Output transfer, not last: idx<=idx+1, stay SEND.
  - Output transfer, last, in_valid=1: buf<=in_vec, idx<=0, stay SEND (back-to-back, no bubble).
  - Output transfer, last, in_valid=0: next IDLE, idx<=0.
  - No output transfer: hold everything; out_data/out_index/out_last stable.
- in_ready in SEND = out_ready && (idx==N-1). This is a combinational path from out_ready to in_ready; it is intentional.
- in_vec is sampled only on an input transfer. Changes on in_vec at any other time have no effect.
- out_last=0 whenever out_valid=0. out_data=buf[idx] always; after reset that is 0.
- N=1: every vector is one beat. out_last=1 whenever out_valid=1. idx stays 0.
- Lane order is always 0..N-1. No reordering and no dropping except on reset.

## Timing
- Reset (synchronous, on the clock edge with reset=1):
  - state=IDLE, idx=0, buf all 0.
  - Resulting outputs: out_valid=0, out_data=0, out_index=0, out_last=0.
  - While reset=1, in_ready=0 and no capture occurs.
- Reset mid-SEND: remaining lanes are discarded. The cycle after reset deasserts, in_ready=1 and out_valid=0.
- Latency: lane 0 is presented on out_data in the cycle after the capturing edge.
- Throughput: with out_ready held at 1 and in_valid continuously high, one lane per cycle. A vector occupies exactly N cycles, with no idle cycle between vectors.
- Backpressure: if out_ready is low for k cycles, the vector takes N+k cycles. The output is held during the stall.
- Simultaneous events in one cycle:
  - The last-lane transfer and a new input transfer both complete.
  - The new vector's lane 0 appears in the next cycle.

## Test plan
- Basic (W=8, N=4, out_ready=1): after reset, drive in_vec={0x11,0x22,0x33,0x44} (lane0..3) for one cycle -> out_data 0x11,0x22,0x33,0x44 on the 4 consecutive cycles starting 1 cycle later. out_index 0,1,2,3. out_last only on 0x44. Then out_valid=0.
- Back-to-back: hold in_valid=1 with vector A={1,2,3,4}, then B={5,6,7,8} at the cycle in_ready pulses -> 8 consecutive valid lanes 1..8, no gap. in_ready high exactly once during A (the cycle lane 3 transfers).
- Backpressure: during vector {0xA0,0xA1,0xA2,0xA3}, drop out_ready for 3 cycles while lane 1 is shown -> out_data stays 0xA1 and out_index stays 1 for those cycles, then 0xA2, 0xA3 follow. in_ready=0 throughout the stall.
- Reset mid-stream: assert reset while lane 2 of {9,8,7,6} is shown -> next cycle out_valid=0, out_data=0, out_index=0. After release, in_ready=1 and a new vector {1,1,1,1} streams from lane 0.
- Wrap/edge values: in_vec={0xFF,0x00,0x80,0x7F} -> exact values emitted unaltered. Separately, run N=1 with in_vec={0x5A} every cycle -> out_data=0x5A, out_last=1 every cycle, and in_ready tracks out_ready.
- Input ignored when busy: change in_vec mid-SEND without an input transfer -> emitted lanes match the captured vector only.

Source files
------------

// File: rtl/vector_lane_serializer.sv
// vector_lane_serializer: captures a whole N-lane vector in one beat and
// emits it lane 0 .. N-1 over a valid/ready handshake. The last-lane transfer
// can overlap the next capture, so back-to-back vectors stream with no bubble.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no vector held; in_ready high (outside reset), out_valid low
// SEND  | presenting lane_buf[idx]; advances on each output transfer
module vector_lane_serializer #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec [N],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [W-1:0]  lane_buf [N];
    logic          capture;
    logic          is_last;
    logic          in_xfer;
    logic          out_xfer;

    assign is_last   = (idx == LAST_IDX);
    assign out_data  = lane_buf[idx];
    assign out_index = idx;

    // State, lane index and vector buffer registers; buffer loads only on capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < N; i++) begin
                lane_buf[i] <= '0;
            end
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (capture) begin
                for (int i = 0; i < N; i++) begin
                    lane_buf[i] <= in_vec[i];
                end
            end
        end
    end

    // Next-state, handshake outputs and capture decision.
    // in_ready in SEND follows out_ready combinationally so the last lane and
    // the next vector can both transfer on the same edge.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        in_xfer    = 1'b0;
        out_xfer   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                in_xfer  = in_valid && in_ready;
                if (in_xfer) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = is_last;
                in_ready  = !reset && out_ready && is_last;
                in_xfer   = in_valid && in_ready;
                out_xfer  = out_valid && out_ready;
                if (out_xfer) begin
                    if (!is_last) begin
                        idx_next = idx + 1'b1;
                    end else begin
                        idx_next = '0;
                        if (in_xfer) begin
                            capture    = 1'b1;
                            state_next = SEND;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Directed bench for vector_lane_serializer: a W=8/N=4 instance for the
// streaming cases and a W=8/N=1 instance for the single-lane case.
module tb_vector_lane_serializer;

    logic       clock;
    logic       reset;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec [4];
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_last;

    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] in_vec1 [1];
    logic       out_valid1;
    logic       out_ready1;
    logic [7:0] out_data1;
    logic [0:0] out_index1;
    logic       out_last1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_lane [4];

    vector_lane_serializer #(.W(8), .N(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    vector_lane_serializer #(.W(8), .N(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_vec    (in_vec1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_index (out_index1),
        .out_last  (out_last1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        in_vec[0] = a;
        in_vec[1] = b;
        in_vec[2] = c;
        in_vec[3] = d;
    endtask

    task automatic set_exp(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        exp_lane[0] = a;
        exp_lane[1] = b;
        exp_lane[2] = c;
        exp_lane[3] = d;
    endtask

    task automatic chk_lane(input string tag, input logic [7:0] data,
                            input logic [1:0] index, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(data));
        chk({tag, "_index"}, 32'(out_index), 32'(index));
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        set_vec(8'h00, 8'h00, 8'h00, 8'h00);
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        in_vec1[0] = 8'h00;

        // reset
        #1;
        chk("rst_in_ready_during", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        chk("rst_in_ready_held", 32'(in_ready), 32'd0);
        chk_idle("rst");
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst1_valid", 32'(out_valid1), 32'd0);
        chk("rst1_data",  32'(out_data1),  32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_released", 32'(in_ready), 32'd1);

        // basic
        cyc();
        in_valid = 1'b1;
        set_vec(8'h11, 8'h22, 8'h33, 8'h44);
        set_exp(8'h11, 8'h22, 8'h33, 8'h44);
        #1;
        chk("basic_ready_idle", 32'(in_ready), 32'd1);
        chk("basic_valid_idle", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            chk_lane("basic_lane", exp_lane[i], 2'(i), (i == 3));
        end
        cyc();
        #1;
        chk_idle("basic_end");
        chk("basic_end_ready", 32'(in_ready), 32'd1);

        // back-to-back A then B
        cyc();
        in_valid = 1'b1;
        set_vec(8'd1, 8'd2, 8'd3, 8'd4);
        #1;
        chk("b2b_ready_idle", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 3) set_vec(8'd5, 8'd6, 8'd7, 8'd8);
            if (k == 7) in_valid = 1'b0;
            #1;
            chk_lane("b2b_lane", 8'(k + 1), 2'(k % 4), (k % 4 == 3));
            chk("b2b_in_ready", 32'(in_ready), 32'((k % 4) == 3));
        end
        cyc();
        #1;
        chk_idle("b2b_end");

        // backpressure, with a junk vector offered during the stall
        cyc();
        in_valid = 1'b1;
        set_vec(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        cyc();
        in_valid = 1'b0;
        #1;
        chk_lane("bp_lane0", 8'hA0, 2'd0, 1'b0);
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        #1;
        chk_lane("bp_stall", 8'hA1, 2'd1, 1'b0);
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        for (int s = 0; s < 2; s++) begin
            cyc();
            #1;
            chk_lane("bp_stall", 8'hA1, 2'd1, 1'b0);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
        end
        cyc();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk_lane("bp_release", 8'hA1, 2'd1, 1'b0);
        cyc();
        #1;
        chk_lane("bp_lane2", 8'hA2, 2'd2, 1'b0);
        cyc();
        #1;
        chk_lane("bp_lane3", 8'hA3, 2'd3, 1'b1);
        cyc();
        #1;
        chk_idle("bp_end");

        // reset mid-stream
        cyc();
        in_valid = 1'b1;
        set_vec(8'd9, 8'd8, 8'd7, 8'd6);
        #1;
        cyc();
        in_valid = 1'b0;
        #1;
        chk_lane("mid_lane0", 8'd9, 2'd0, 1'b0);
        cyc();
        #1;
        chk_lane("mid_lane1", 8'd8, 2'd1, 1'b0);
        cyc();
        #1;
        chk_lane("mid_lane2", 8'd7, 2'd2, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_ready_in_reset", 32'(in_ready), 32'd0);
        cyc();
        #1;
        chk_idle("mid_after_reset");
        chk("mid_data",  32'(out_data),  32'd0);
        chk("mid_index", 32'(out_index), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_ready_release", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        set_vec(8'd1, 8'd1, 8'd1, 8'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b0;
            #1;
            chk_lane("mid_new", 8'd1, 2'(i), (i == 3));
        end
        cyc();
        #1;
        chk_idle("mid_end");

        // edge values, in_vec scribbled while busy without a transfer
        cyc();
        in_valid = 1'b1;
        set_vec(8'hFF, 8'h00, 8'h80, 8'h7F);
        set_exp(8'hFF, 8'h00, 8'h80, 8'h7F);
        #1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b0;
            set_vec(8'(8'h55 + i), 8'h3C, 8'hC3, 8'(8'h10 * i));
            #1;
            chk_lane("edge_lane", exp_lane[i], 2'(i), (i == 3));
        end
        cyc();
        #1;
        chk_idle("edge_end");

        // N=1 instance
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        in_vec1[0] = 8'h5A;
        #1;
        chk("n1_ready_idle", 32'(in_ready1), 32'd1);
        chk("n1_valid_idle", 32'(out_valid1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("n1_valid", 32'(out_valid1), 32'd1);
            chk("n1_data",  32'(out_data1),  32'h5A);
            chk("n1_last",  32'(out_last1),  32'd1);
            chk("n1_index", 32'(out_index1), 32'd0);
            chk("n1_ready", 32'(in_ready1),  32'd1);
        end
        out_ready1 = 1'b0;
        #1;
        chk("n1_ready_stall", 32'(in_ready1), 32'd0);
        cyc();
        #1;
        chk("n1_valid_stall", 32'(out_valid1), 32'd1);
        chk("n1_data_stall",  32'(out_data1),  32'h5A);
        chk("n1_last_stall",  32'(out_last1),  32'd1);
        chk("n1_ready_stall", 32'(in_ready1),  32'd0);
        out_ready1 = 1'b1;
        in_valid1  = 1'b0;
        #1;
        chk("n1_ready_resume", 32'(in_ready1), 32'd1);
        cyc();
        #1;
        chk("n1_valid_end", 32'(out_valid1), 32'd0);
        chk("n1_last_end",  32'(out_last1),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
